// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-stage types: word width, NOP encoding, fetch FSM states and IF/ID payload.
package rv32_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } if_id_t;

    // Sequential successor address; wraps silently at the top of the address space.
    function automatic logic [XLEN-1:0] pc_next_seq(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
interface inst_fetch_if;
    import rv32_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register plus a one-entry hold buffer for a response that arrives while decode stalls.
module if_id_reg
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP      = 32'h0000_0013
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   stall_id,
    input  logic   flush,
    input  logic   load_id,
    input  logic   load_hold,
    input  logic   move_hold,
    input  if_id_t fetched,
    output if_id_t id_q,
    output logic   id_free_c
);

    if_id_t hold_q;

    // Register can take a new entry when empty or when decode consumes it this cycle.
    assign id_free_c = !id_q.valid || !stall_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            id_q   <= '{valid: 1'b0, inst: NOP, pc: RESET_PC, pc_plus4: pc_next_seq(RESET_PC)};
            hold_q <= '0;
        end else if (flush) begin
            id_q.valid   <= 1'b0;
            id_q.inst    <= NOP;
            hold_q.valid <= 1'b0;
        end else begin
            if (load_id) begin
                id_q <= fetched;
            end else if (move_hold) begin
                id_q         <= hold_q;
                hold_q.valid <= 1'b0;
            end else if (id_free_c) begin
                // Consumed with nothing to replace it: present a bubble.
                id_q.valid <= 1'b0;
                id_q.inst  <= NOP;
            end
            if (load_hold) begin
                hold_q <= fetched;
            end
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// RV32I fetch stage: PC, one-outstanding imem requests, redirect handling, IF/ID delivery.
// Build option FETCH_MISALIGN_TRAP_EN: misaligned redirects raise fetch_misalign instead of being aligned.
module inst_fetch
    import rv32_pkg::XLEN, rv32_pkg::if_id_t, rv32_pkg::fetch_state_t, rv32_pkg::pc_next_seq,
           rv32_pkg::ISSUE, rv32_pkg::WAIT, rv32_pkg::HOLD, rv32_pkg::DROP;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = rv32_pkg::NOP_INST
) (
    input  logic              clk,
    input  logic              reset,
    inst_fetch_if.master      imem,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              stall_id,
    output logic              id_valid,
    output logic [XLEN-1:0]   id_inst,
    output logic [XLEN-1:0]   id_pc,
    output logic [XLEN-1:0]   id_pc_plus4,
    output logic              fetch_misalign
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic            req_q;
    logic            id_free_c;
    logic            rsp_accept_c;
    logic            drop_c;
    logic            redirect_take_c;
    logic [XLEN-1:0] redirect_tgt_c;
    if_id_t          fetched;
    if_id_t          id_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_c;

    assign misalign_c      = |redirect_pc[1:0];
    assign redirect_tgt_c  = redirect_pc;
    assign redirect_take_c = redirect_valid && !misalign_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_misalign <= 1'b0;
        end else begin
            fetch_misalign <= redirect_valid && misalign_c;
        end
    end
`else
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redirect_tgt_c      = {redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_take_c     = redirect_valid;
    assign fetch_misalign      = 1'b0;
`endif

    // A response is kept only in WAIT and only when no redirect squashes it.
    assign rsp_accept_c = (state == WAIT) && imem.imem_rvalid && !redirect_valid;

    // On redirect, a request still owed a response must be drained through DROP.
    assign drop_c = ((state == ISSUE) && req_q) ||
                    (((state == WAIT) || (state == DROP)) && !imem.imem_rvalid);

    assign fetched = '{valid: 1'b1, inst: imem.imem_rdata, pc: pc, pc_plus4: pc_next_seq(pc)};

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_take_c) begin
            pc <= redirect_tgt_c;
        end else if (rsp_accept_c) begin
            pc <= pc_next_seq(pc);
        end
    end

    // Fetch FSM; req_q is registered so it stays low through reset and the first cycle after.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ISSUE;
            req_q <= 1'b0;
        end else if (redirect_valid) begin
            if (drop_c) begin
                state <= DROP;
                req_q <= 1'b0;
            end else begin
                state <= ISSUE;
                req_q <= 1'b1;
            end
        end else begin
            case (state)
                ISSUE: begin
                    state <= req_q ? WAIT : ISSUE;
                    req_q <= !req_q;
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        state <= id_free_c ? ISSUE : HOLD;
                        req_q <= id_free_c;
                    end
                end
                HOLD: begin
                    if (id_free_c) begin
                        state <= ISSUE;
                        req_q <= 1'b1;
                    end
                end
                DROP: begin
                    if (imem.imem_rvalid) begin
                        state <= ISSUE;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= ISSUE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg #(
        .RESET_PC (RESET_PC),
        .NOP      (NOP_INST)
    ) u_if_id_reg (
        .clk       (clk),
        .reset     (reset),
        .stall_id  (stall_id),
        .flush     (redirect_valid),
        .load_id   (rsp_accept_c && id_free_c),
        .load_hold (rsp_accept_c && !id_free_c),
        .move_hold ((state == HOLD) && id_free_c && !redirect_valid),
        .fetched   (fetched),
        .id_q      (id_q),
        .id_free_c (id_free_c)
    );

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;
    assign id_valid       = id_q.valid;
    assign id_inst        = id_q.inst;
    assign id_pc          = id_q.pc;
    assign id_pc_plus4    = id_q.pc_plus4;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then random stall/redirect/latency traffic against an
// instruction-stream reference model and a behavioural instruction memory.
module tb_inst_fetch;
    import rv32_pkg::*;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_id;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fetch_misalign;

    inst_fetch_if bus();

    inst_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .imem           (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_id       (stall_id),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_pc;
    bit          exp_known;
    int          consumed;
    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int unsigned lat_min;
    int unsigned lat_max;
    bit          prev_rv;
    bit          prev_mis;
    int          cyc;
    logic [31:0] req_addr_q[$];
    int          req_cyc_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0F00;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at a negedge: check current outputs, play memory, drive inputs for the next edge.
    task automatic step(input logic st, input logic rv, input logic [31:0] rt);
        bit was_pend;
        bit rsp;
        if (!id_valid) check("idle_inst", id_inst, NOP_INST);
        if (prev_rv) check("flush_valid", 32'(id_valid), 32'd0);
        check("misalign_flag", 32'(fetch_misalign), 32'(prev_rv && prev_mis && TRAP_EN));
        if (id_valid && !st && !rv) begin
            if (!exp_known) begin
                exp_pc    = id_pc;
                exp_known = 1'b1;
            end else begin
                check("id_pc", id_pc, exp_pc);
            end
            check("id_inst", id_inst, mem_word(exp_pc));
            check("id_pc_plus4", id_pc_plus4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        if (rv) begin
            if (TRAP_EN && (rt[1:0] != 2'b00)) exp_known = 1'b0;
            else begin
                exp_pc    = {rt[31:2], 2'b00};
                exp_known = 1'b1;
            end
        end
        was_pend = mem_pend;
        rsp      = 1'b0;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                rsp      = 1'b1;
                mem_pend = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        bus.imem_rvalid = rsp;
        bus.imem_rdata  = rsp ? mem_word(mem_addr) : $urandom();
        if (bus.imem_req) begin
            check("one_outstanding", 32'(was_pend), 32'd0);
            check("addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
            req_addr_q.push_back(bus.imem_addr);
            req_cyc_q.push_back(cyc);
            mem_pend = 1'b1;
            mem_addr = bus.imem_addr;
            mem_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
        end
        stall_id       = st;
        redirect_valid = rv;
        redirect_pc    = rt;
        prev_rv        = rv;
        prev_mis       = (rt[1:0] != 2'b00);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until_req(input string tag);
        for (int i = 0; i < 20 && !bus.imem_req; i++) step(1'b0, 1'b0, 32'd0);
        check(tag, 32'(bus.imem_req), 32'd1);
    endtask

    initial begin
        logic [31:0] p;
        logic [31:0] a;
        int          nreq;
        logic        st;
        logic        rv;
        logic [31:0] rt;

        reset = 1'b1; stall_id = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        exp_pc = 32'd0; exp_known = 1'b1; consumed = 0; mem_pend = 1'b0; mem_addr = '0;
        mem_cnt = 0; lat_min = 1; lat_max = 1; prev_rv = 1'b0; prev_mis = 1'b0; cyc = 0;

        repeat (3) @(negedge clk);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_inst", id_inst, NOP_INST);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_pc_plus4", id_pc_plus4, 32'd4);
        check("rst_imem_req", 32'(bus.imem_req), 32'd0);
        check("rst_misalign", 32'(fetch_misalign), 32'd0);
        reset = 1'b0;

        // Sequential fetch at 1-cycle latency: addresses 0,4,8,12 every second cycle.
        repeat (16) step(1'b0, 1'b0, 32'd0);
        check("t1_req_count", 32'(req_addr_q.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < req_addr_q.size()) begin
                check("t1_addr", req_addr_q[i], 32'(i * 4));
                if (i > 0) check("t1_gap", 32'(req_cyc_q[i] - req_cyc_q[i-1]), 32'd2);
            end
        end

        // Decode stall: next word parks in the hold buffer, no further requests.
        for (int i = 0; i < 8 && !id_valid; i++) step(1'b0, 1'b0, 32'd0);
        check("t2_id_valid", 32'(id_valid), 32'd1);
        p    = id_pc;
        nreq = req_addr_q.size();
        repeat (5) begin
            step(1'b1, 1'b0, 32'd0);
            check("t2_stall_pc", id_pc, p);
        end
        check("t2_one_req", 32'(req_addr_q.size() - nreq), 32'd1);
        check("t2_req_addr", req_addr_q[req_addr_q.size() - 1], p + 32'd4);
        step(1'b0, 1'b0, 32'd0);
        check("t2_rel_valid", 32'(id_valid), 32'd1);
        check("t2_rel_pc", id_pc, p + 32'd4);
        check("t2_resume_req", 32'(bus.imem_req), 32'd1);
        check("t2_resume_addr", bus.imem_addr, p + 32'd8);

        // Redirect while waiting on a 3-cycle response: response dropped, refetch at 0x100.
        lat_min = 3; lat_max = 3;
        run_until_req("t3_reach");
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'h100);
        repeat (2) begin
            check("t3_drop_valid", 32'(id_valid), 32'd0);
            check("t3_drop_noreq", 32'(bus.imem_req), 32'd0);
            step(1'b0, 1'b0, 32'd0);
        end
        check("t3_req", 32'(bus.imem_req), 32'd1);
        check("t3_addr", bus.imem_addr, 32'h100);
        check("t3_valid", 32'(id_valid), 32'd0);
        lat_min = 1; lat_max = 1;
        repeat (6) step(1'b0, 1'b0, 32'd0);

        // Redirect coinciding with the response and a decode stall.
        run_until_req("t4_reach");
        step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h200);
        check("t4_valid", 32'(id_valid), 32'd0);
        check("t4_req", 32'(bus.imem_req), 32'd1);
        check("t4_addr", bus.imem_addr, 32'h200);
        repeat (6) step(1'b0, 1'b0, 32'd0);

        // Jump to the last word: next fetch wraps to 0.
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 12 && !(id_valid && id_pc == 32'hFFFF_FFFC); i++) step(1'b0, 1'b0, 32'd0);
        check("t5_pc", id_pc, 32'hFFFF_FFFC);
        check("t5_pc_plus4", id_pc_plus4, 32'd0);
        check("t5_next_req", 32'(bus.imem_req), 32'd1);
        check("t5_next_addr", bus.imem_addr, 32'd0);
        repeat (4) step(1'b0, 1'b0, 32'd0);

        // Misaligned redirect target.
        run_until_req("t6_reach");
        a = bus.imem_addr;
        step(1'b0, 1'b1, 32'h102);
        check("t6_flag", 32'(fetch_misalign), 32'(TRAP_EN));
        step(1'b0, 1'b0, 32'd0);
        check("t6_flag_pulse", 32'(fetch_misalign), 32'd0);
        check("t6_req", 32'(bus.imem_req), 32'd1);
        check("t6_addr", bus.imem_addr, TRAP_EN ? a : 32'h100);
        repeat (4) step(1'b0, 1'b0, 32'd0);

        // Random traffic.
        lat_min = 1; lat_max = 3;
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(2, 0) == 0);
            rv = ($urandom_range(19, 0) == 0);
            rt = $urandom() & 32'h0000_FFFF;
            if ($urandom_range(9, 0) == 0) rt = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
            step(st, rv, rt);
        end
        repeat (8) step(1'b0, 1'b0, 32'd0);
        check("progress", 32'(consumed > 200), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
